factor_game_control: RTL and testbench

- Top-level sequencer for the factorization quiz game.
- Steps play through idle, ready, question, answer input, judgement, result display, stage clear and game over.
- Gates the player's selector and decide inputs through to the datapath.
- Publishes the current state code for the display and question blocks.

---
 rtl/factor_game_control.sv | 161 ++++++++++++++++
 tb/tb_factor_game_control.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/factor_game_control.sv
// factor_game_control: quiz game sequencer; every transition one clock after its qualifying sample; no backpressure.
// Define CONTROL_DEBUG_EN to add the CNT and NEED_1SEC debug outputs.
module factor_game_control #(
    parameter int WAIT_CYCLES = 8,
    parameter int CLEAR_GOAL  = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       READY_IN,
    input  logic       QUE_IN,
    input  logic [2:0] SEL,
    input  logic       DEC,
    input  logic       CLR_IN,
    input  logic       OK_IN,
    input  logic [1:0] HP_IN,
    input  logic       QUE,
    input  logic [1:0] JUDG_IN,
    input  logic [1:0] WRONG_IN,
    output logic       READY_OUT,
    output logic [3:0] STATE,
    output logic [2:0] SEL_OUT,
    output logic       DEC_OUT,
    output logic       CLR_OUT
`ifdef CONTROL_DEBUG_EN
    ,
    output logic [2:0] CNT,
    output logic       NEED_1SEC
`endif
);

    localparam int TW = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        READY     = 4'd1,
        QUESTION  = 4'd2,
        INPUT     = 4'd3,
        JUDGE     = 4'd4,
        RESULT_OK = 4'd5,
        RESULT_NG = 4'd6,
        CLEAR     = 4'd7,
        OVER      = 4'd8
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_dec_prev;
    logic            r_clr_prev;
    logic [2:0]      r_cnt;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_sel_out;
    logic            r_dec_out;
    logic            r_clr_out;

    logic            w_dec_rise;
    logic            w_clr_rise;
    logic            w_forced;
    logic            w_in_result;
    logic            w_wait_done;
    logic            w_take_dec;
    logic            w_take_clr;
    logic            w_cnt_inc;

    assign w_dec_rise  = DEC & ~r_dec_prev;
    assign w_clr_rise  = CLR_IN & ~r_clr_prev;
    assign w_in_result = (r_state == RESULT_OK) || (r_state == RESULT_NG);
    assign w_wait_done = (r_timer == TW'(WAIT_CYCLES - 1));
    assign w_forced    = (WRONG_IN == 2'b11) &&
                         (r_state inside {QUESTION, INPUT, JUDGE, RESULT_NG});

    always_comb begin
        w_next     = r_state;
        w_take_dec = 1'b0;
        w_take_clr = 1'b0;
        w_cnt_inc  = 1'b0;
        case (r_state)
            IDLE:      if (READY_IN) w_next = READY;
            READY:     if (OK_IN && QUE) w_next = QUESTION;
            QUESTION:  if (QUE_IN) w_next = INPUT;
            INPUT: begin
                if (w_dec_rise) begin
                    w_next     = JUDGE;
                    w_take_dec = 1'b1;
                end
            end
            JUDGE: begin
                if (JUDG_IN == 2'b01) begin
                    w_next    = RESULT_OK;
                    w_cnt_inc = 1'b1;
                end else if (JUDG_IN == 2'b10) begin
                    w_next = RESULT_NG;
                end
            end
            RESULT_OK: begin
                if (w_wait_done)
                    w_next = (r_cnt == 3'(CLEAR_GOAL)) ? CLEAR : QUESTION;
            end
            RESULT_NG: begin
                if (w_wait_done)
                    w_next = (HP_IN == 2'b00) ? OVER : QUESTION;
            end
            CLEAR, OVER: begin
                if (w_clr_rise) begin
                    w_next     = IDLE;
                    w_take_clr = 1'b1;
                end
            end
            default:   w_next = IDLE;
        endcase
        // A forced loss beats every other exit, including a submit in the same clock
        if (w_forced) begin
            w_next     = OVER;
            w_take_dec = 1'b0;
            w_cnt_inc  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_dec_prev <= 1'b0;
            r_clr_prev <= 1'b0;
            r_cnt      <= '0;
            r_timer    <= '0;
            r_sel_out  <= '0;
            r_dec_out  <= 1'b0;
            r_clr_out  <= 1'b0;
        end else begin
            r_dec_prev <= DEC;
            r_clr_prev <= CLR_IN;
            r_dec_out  <= w_take_dec;
            r_clr_out  <= w_take_clr;
            if (r_state == INPUT)
                r_sel_out <= SEL;
            if (w_take_clr)
                r_cnt <= '0;
            else if (w_cnt_inc)
                r_cnt <= r_cnt + 3'd1;
            if (w_next != r_state)
                r_timer <= '0;
            else if (w_in_result && !w_wait_done)
                r_timer <= r_timer + TW'(1);
        end
    end

    assign READY_OUT = (r_state == READY);
    assign STATE     = r_state;
    assign SEL_OUT   = r_sel_out;
    assign DEC_OUT   = r_dec_out;
    assign CLR_OUT   = r_clr_out;

`ifdef CONTROL_DEBUG_EN
    assign CNT       = r_cnt;
    assign NEED_1SEC = w_in_result;
`endif

endmodule

// File: tb/tb_factor_game_control.sv
// Directed bench for factor_game_control: vector table plus multi-cycle round sequences.
module tb_factor_game_control;

    logic       clk;
    logic       rst_n;
    logic       ready_in, que_in, dec, clr_in, ok_in, que;
    logic [2:0] sel;
    logic [1:0] hp_in, judg_in, wrong_in;
    logic       ready_out, dec_out, clr_out;
    logic [3:0] state;
    logic [2:0] sel_out;

    int checks = 0;
    int errors = 0;

    factor_game_control #(.WAIT_CYCLES(8), .CLEAR_GOAL(3)) dut (
        .CLK(clk), .RST(rst_n), .READY_IN(ready_in), .QUE_IN(que_in), .SEL(sel),
        .DEC(dec), .CLR_IN(clr_in), .OK_IN(ok_in), .HP_IN(hp_in), .QUE(que),
        .JUDG_IN(judg_in), .WRONG_IN(wrong_in), .READY_OUT(ready_out), .STATE(state),
        .SEL_OUT(sel_out), .DEC_OUT(dec_out), .CLR_OUT(clr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ready_in;
        logic       que_in;
        logic [2:0] sel;
        logic       dec;
        logic       clr_in;
        logic       ok_in;
        logic [1:0] hp_in;
        logic       que;
        logic [1:0] judg_in;
        logic [1:0] wrong_in;
        logic [3:0] exp_state;
        logic       exp_ready;
        logic [2:0] exp_sel;
        logic       exp_dec;
        logic       exp_clr;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ready_in = 1'b0; que_in = 1'b0; sel = 3'd0; dec = 1'b0; clr_in = 1'b0;
        ok_in = 1'b0; hp_in = 2'd2; que = 1'b0; judg_in = 2'd0; wrong_in = 2'd0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic go_question();
        ready_in = 1'b1; tick(); chk("to_ready", state, 4'd1); chk("ready_out", ready_out, 1);
        ready_in = 1'b0; ok_in = 1'b1; que = 1'b1;
        tick(); chk("to_question", state, 4'd2);
        ok_in = 1'b0; que = 1'b0;
    endtask

    // Runs QUESTION -> INPUT -> JUDGE -> RESULT_x and the full dwell.
    task automatic round(input logic [1:0] judg, input logic [1:0] hp, input logic [3:0] fin);
        logic [3:0] res;
        res = (judg == 2'b01) ? 4'd5 : 4'd6;
        que_in = 1'b1; tick(); chk("rnd_input", state, 4'd3);
        que_in = 1'b0; sel = 3'd3; dec = 1'b0; tick(); chk("rnd_hold_input", state, 4'd3);
        dec = 1'b1; tick(); chk("rnd_judge", state, 4'd4); chk("rnd_dec_pulse", dec_out, 1);
        chk("rnd_sel_out", sel_out, 3);
        dec = 1'b0; tick(); chk("rnd_judge_hold", state, 4'd4); chk("rnd_dec_low", dec_out, 0);
        hp_in = hp; judg_in = judg; tick(); chk("rnd_result", state, res);
        judg_in = 2'd0;
        for (int i = 1; i < 8; i++) begin
            tick(); chk("rnd_dwell", state, res);
        end
        tick(); chk("rnd_after_dwell", state, fin);
        hp_in = 2'd2;
    endtask

    task automatic restart();
        clr_in = 1'b1; tick(); chk("clr_to_idle", state, 4'd0); chk("clr_pulse", clr_out, 1);
        clr_in = 1'b0; tick(); chk("clr_pulse_end", clr_out, 0); chk("clr_idle_hold", state, 4'd0);
    endtask

    initial begin
        //            rdy   quein sel   dec   clr   ok    hp     que   judg   wrong   st     rdy   selo  dec   clr
        vecs[0]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 2'd0, 4'd1, 1'b1, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 2'd3, 4'd1, 1'b1, 3'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 4'd1, 1'b1, 3'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 2'd0, 2'd0, 4'd2, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 2'd0, 4'd2, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 2'd0, 4'd3, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 2'd0, 4'd3, 1'b0, 3'd5, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 2'd0, 4'd4, 1'b0, 3'd5, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 2'd0, 4'd4, 1'b0, 3'd5, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 2'd0, 4'd4, 1'b0, 3'd5, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 2'd3, 2'd0, 4'd4, 1'b0, 3'd5, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 2'd1, 2'd0, 4'd5, 1'b0, 3'd5, 1'b0, 1'b0};

        // Reset held with busy stimulus: everything must stay at zero
        rst_n = 1'b0;
        idle_inputs();
        ready_in = 1'b1; que_in = 1'b1; dec = 1'b1; clr_in = 1'b1; ok_in = 1'b1; que = 1'b1;
        sel = 3'd7; judg_in = 2'd1;
        repeat (3) tick();
        chk("rst_state", state, 0); chk("rst_ready", ready_out, 0); chk("rst_sel", sel_out, 0);
        chk("rst_dec", dec_out, 0); chk("rst_clr", clr_out, 0);
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick(); chk("post_rst_idle", state, 0);

        for (int i = 0; i < 13; i++) begin
            ready_in = vecs[i].ready_in; que_in = vecs[i].que_in; sel = vecs[i].sel;
            dec = vecs[i].dec; clr_in = vecs[i].clr_in; ok_in = vecs[i].ok_in;
            hp_in = vecs[i].hp_in; que = vecs[i].que; judg_in = vecs[i].judg_in;
            wrong_in = vecs[i].wrong_in;
            tick();
            chk($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
            chk($sformatf("vec%0d_ready", i), ready_out, vecs[i].exp_ready);
            chk($sformatf("vec%0d_sel", i), sel_out, vecs[i].exp_sel);
            chk($sformatf("vec%0d_dec", i), dec_out, vecs[i].exp_dec);
            chk($sformatf("vec%0d_clr", i), clr_out, vecs[i].exp_clr);
        end

        // Finish the first correct round's dwell
        idle_inputs();
        for (int i = 1; i < 8; i++) begin
            tick(); chk("ok1_dwell", state, 4'd5);
        end
        tick(); chk("ok1_back_to_q", state, 4'd2);

        round(2'b01, 2'd2, 4'd2);
        round(2'b01, 2'd2, 4'd7);
        repeat (3) tick();
        chk("clear_holds", state, 4'd7);
        restart();

        // Counter must have been cleared: a wrong answer, then three more correct to clear
        go_question();
        round(2'b10, 2'd2, 4'd2);
        round(2'b01, 2'd2, 4'd2);
        round(2'b01, 2'd2, 4'd2);
        round(2'b01, 2'd2, 4'd7);
        restart();

        go_question();
        round(2'b10, 2'd0, 4'd8);
        repeat (2) tick();
        chk("over_holds", state, 4'd8);
        restart();

        // Single-clock forced loss in INPUT
        go_question();
        que_in = 1'b1; tick(); chk("fl_input", state, 4'd3);
        que_in = 1'b0; wrong_in = 2'd3; tick(); chk("fl_over", state, 4'd8);
        wrong_in = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("fl_stays_over", state, 4'd8);
        end
        restart();

        // Asynchronous reset mid-game, away from any clock edge
        go_question();
        #2 rst_n = 1'b0;
        #1 chk("async_rst_state", state, 0);
        tick();
        rst_n = 1'b1;
        tick(); chk("async_rst_idle", state, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
